// File: rtl/hwpe_dma_loader.sv
// hwpe_dma_loader: preloads FMAP bank 1, FMAP bank 2 and KERNEL into hwpe.
// Optional cycle counter port perf_cycles when HWPE_DMA_PERF_CNT_EN is defined.
module hwpe_dma_loader #(
   parameter int ADDR_W = 16,
   parameter int SRC_AW = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [SRC_AW-1:0] cfg_f1_src,
   input  logic [ADDR_W-1:0] cfg_f1_dst,
   input  logic [LEN_W-1:0]  cfg_f1_len,
   input  logic [SRC_AW-1:0] cfg_f2_src,
   input  logic [ADDR_W-1:0] cfg_f2_dst,
   input  logic [LEN_W-1:0]  cfg_f2_len,
   input  logic [SRC_AW-1:0] cfg_k_src,
   input  logic [ADDR_W-1:0] cfg_k_dst,
   input  logic [LEN_W-1:0]  cfg_k_len,
   output logic              src_req_valid,
   input  logic              src_req_ready,
   output logic [SRC_AW-1:0] src_req_addr,
   input  logic              src_rsp_valid,
   input  logic [63:0]       src_rsp_data,
   output logic              dma_wen,
   output logic [ADDR_W-1:0] dma_wa,
   output logic [63:0]       dma_wd,
   output logic              busy,
   output logic              done,
   output logic              fmap_done,
   output logic              kernel_done,
   output logic              err_start
`ifdef HWPE_DMA_PERF_CNT_EN
   ,
   output logic [31:0]       perf_cycles
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_t;

   localparam logic [1:0] SEG_NONE = 2'd3;

   state_t state, state_nx;

   logic [1:0]              seg;
   logic [LEN_W-1:0]        beat;
   logic [2:0][SRC_AW-1:0]  src_q;
   logic [2:0][ADDR_W-1:0]  dst_q;
   logic [2:0][LEN_W-1:0]   len_q;

   logic [SRC_AW-1:0] cur_src;
   logic [ADDR_W-1:0] cur_dst;
   logic [LEN_W-1:0]  cur_len;
   logic [1:0]        seg_first;
   logic [1:0]        seg_next;
   logic              last_beat;
   logic              accept;
   logic              rsp;

   // First non-empty segment at index >= from; SEG_NONE if none remain.
   function automatic logic [1:0] pick(
      input logic [1:0]       from,
      input logic [LEN_W-1:0] l0,
      input logic [LEN_W-1:0] l1,
      input logic [LEN_W-1:0] l2
   );
      pick = SEG_NONE;
      if (from <= 2'd2 && l2 != '0) pick = 2'd2;
      if (from <= 2'd1 && l1 != '0) pick = 2'd1;
      if (from == 2'd0 && l0 != '0) pick = 2'd0;
   endfunction

   // Current segment descriptor and segment-sequencing decisions.
   always_comb begin
      cur_src = src_q[0];
      cur_dst = dst_q[0];
      cur_len = len_q[0];
      case (seg)
         2'd1: begin
            cur_src = src_q[1];
            cur_dst = dst_q[1];
            cur_len = len_q[1];
         end
         2'd2: begin
            cur_src = src_q[2];
            cur_dst = dst_q[2];
            cur_len = len_q[2];
         end
         default: ;
      endcase
      seg_first = pick(2'd0, cfg_f1_len, cfg_f2_len, cfg_k_len);
      seg_next  = pick(seg + 2'd1, len_q[0], len_q[1], len_q[2]);
      last_beat = (beat == cur_len - LEN_W'(1));
   end

   assign accept        = start && (state == IDLE);
   assign rsp           = src_rsp_valid && (state == WAIT);
   assign src_req_valid = (state == REQ);
   assign src_req_addr  = cur_src + (SRC_AW'(beat) << 3);
   assign busy          = (state != IDLE);
   assign done          = (state == FIN);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // FSM next state: one outstanding read, FIN marks the end of a load.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start)
            state_nx = (seg_first == SEG_NONE) ? FIN : REQ;
         REQ: if (src_req_ready)
            state_nx = WAIT;
         WAIT: if (src_rsp_valid)
            state_nx = (last_beat && seg_next == SEG_NONE) ? FIN : REQ;
         FIN: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Config latch, beat/segment tracking, write port and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg         <= 2'd0;
         beat        <= '0;
         src_q       <= '0;
         dst_q       <= '0;
         len_q       <= '0;
         dma_wen     <= 1'b0;
         dma_wa      <= '0;
         dma_wd      <= '0;
         fmap_done   <= 1'b0;
         kernel_done <= 1'b0;
         err_start   <= 1'b0;
      end else begin
         dma_wen <= 1'b0;
         if (accept) begin
            src_q       <= {cfg_k_src, cfg_f2_src, cfg_f1_src};
            dst_q       <= {cfg_k_dst, cfg_f2_dst, cfg_f1_dst};
            len_q       <= {cfg_k_len, cfg_f2_len, cfg_f1_len};
            seg         <= (seg_first == SEG_NONE) ? 2'd0 : seg_first;
            beat        <= '0;
            fmap_done   <= (seg_first >= 2'd2);
            kernel_done <= (seg_first == SEG_NONE);
            err_start   <= 1'b0;
         end else if (start) begin
            err_start <= 1'b1;
         end
         if (rsp) begin
            dma_wen <= 1'b1;
            dma_wa  <= cur_dst + (ADDR_W'(beat) << 3);
            dma_wd  <= src_rsp_data;
            if (last_beat) begin
               beat <= '0;
               if (seg_next != SEG_NONE) seg <= seg_next;
               if (seg_next >= 2'd2) fmap_done <= 1'b1;
               if (seg_next == SEG_NONE) kernel_done <= 1'b1;
            end else begin
               beat <= beat + LEN_W'(1);
            end
         end
      end
   end

`ifdef HWPE_DMA_PERF_CNT_EN
   // Busy-cycle counter: cleared on accepted start, saturating, frozen when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         perf_cycles <= '0;
      else if (accept)
         perf_cycles <= '0;
      else if (busy && perf_cycles != 32'hFFFF_FFFF)
         perf_cycles <= perf_cycles + 32'd1;
   end
`else
   // No cycle counter in this build.
`endif

endmodule

// File: tb/tb_hwpe_dma_loader.sv
// tb_hwpe_dma_loader: directed and random loads against a segment-list model.
// Responder and checks run in one process; HWPE_DMA_PERF_CNT_EN adds perf checks.
module tb_hwpe_dma_loader;

   localparam int AW = 16;
   localparam int SW = 32;
   localparam int LW = 16;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [SW-1:0] c_src [3];
   logic [AW-1:0] c_dst [3];
   logic [LW-1:0] c_len [3];
   logic          src_req_valid;
   logic          src_req_ready = 1'b1;
   logic [SW-1:0] src_req_addr;
   logic          src_rsp_valid = 1'b0;
   logic [63:0]   src_rsp_data  = '0;
   logic          dma_wen;
   logic [AW-1:0] dma_wa;
   logic [63:0]   dma_wd;
   logic          busy, done, fmap_done, kernel_done, err_start;
`ifdef HWPE_DMA_PERF_CNT_EN
   logic [31:0]   perf_cycles;
`endif

   int            n_assert = 0;
   int            n_fail   = 0;
   logic [63:0]   seed;
   int            lat        = 1;
   int            pend       = 0;
   logic [SW-1:0] paddr      = '0;
   int            stall_left = 0;
   logic [SW-1:0] stall_addr = '0;
   bit            held       = 1'b0;
   logic [SW-1:0] held_addr  = '0;
   logic [AW-1:0] got_wa [$];
   logic [63:0]   got_wd [$];

   hwpe_dma_loader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .cfg_f1_src   (c_src[0]),
      .cfg_f1_dst   (c_dst[0]),
      .cfg_f1_len   (c_len[0]),
      .cfg_f2_src   (c_src[1]),
      .cfg_f2_dst   (c_dst[1]),
      .cfg_f2_len   (c_len[1]),
      .cfg_k_src    (c_src[2]),
      .cfg_k_dst    (c_dst[2]),
      .cfg_k_len    (c_len[2]),
      .src_req_valid(src_req_valid),
      .src_req_ready(src_req_ready),
      .src_req_addr (src_req_addr),
      .src_rsp_valid(src_rsp_valid),
      .src_rsp_data (src_rsp_data),
      .dma_wen      (dma_wen),
      .dma_wa       (dma_wa),
      .dma_wd       (dma_wd),
      .busy         (busy),
      .done         (done),
      .fmap_done    (fmap_done),
      .kernel_done  (kernel_done),
      .err_start    (err_start)
`ifdef HWPE_DMA_PERF_CNT_EN
      ,
      .perf_cycles  (perf_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Source memory contents as a function of byte address.
   function automatic logic [63:0] mem(input logic [31:0] a);
      return {a ^ seed[31:0], (~a) + seed[63:32]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and play the source-memory side.
   task automatic tick();
      @(negedge clk);
      src_rsp_valid = 1'b0;
      if (!rst_n) pend = 0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            src_rsp_valid = 1'b1;
            src_rsp_data  = mem(paddr);
         end
      end
      if (held) begin
         chk("stall_valid_held", src_req_valid, 1);
         chk("stall_addr_stable", src_req_addr, held_addr);
      end
      held = 1'b0;
      src_req_ready = 1'b1;
      if (src_req_valid && stall_left > 0 && src_req_addr == stall_addr) begin
         src_req_ready = 1'b0;
         stall_left--;
         held      = 1'b1;
         held_addr = src_req_addr;
      end
      if (src_req_valid && src_req_ready) begin
         pend  = lat;
         paddr = src_req_addr;
      end
   endtask

   task automatic set_seg(input int s, input logic [SW-1:0] sa,
                          input logic [AW-1:0] da, input logic [LW-1:0] l);
      c_src[s] = sa;
      c_dst[s] = da;
      c_len[s] = l;
   endtask

   // One complete load; inj >= 0 pulses a stray start at that cycle.
   task automatic run_load(input string tag, input int inj, input int exp_k);
      logic [AW-1:0] ewa [$];
      logic [63:0]   ewd [$];
      logic [AW-1:0] a;
      int nf, nt, done_k, first_k, nreq, bad;
      nf = int'(c_len[0]) + int'(c_len[1]);
      nt = nf + int'(c_len[2]);
      for (int s = 0; s < 3; s++)
         for (int i = 0; i < int'(c_len[s]); i++) begin
            a = c_dst[s] + AW'(8 * i);
            ewa.push_back(a);
            ewd.push_back(mem(c_src[s] + SW'(8 * i)));
         end
      got_wa.delete();
      got_wd.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "/busy_first"}, busy, 1);
      chk({tag, "/err_cleared"}, err_start, 0);
      chk({tag, "/fmap_first"}, fmap_done, (nf == 0));
      chk({tag, "/kernel_first"}, kernel_done, (nt == 0));
      done_k = -1;
      first_k = -1;
      nreq = 0;
      for (int k = 0; k < 12000; k++) begin
         if (src_req_valid) nreq++;
         if (dma_wen) begin
            chk({tag, "/fmap_at_write"}, fmap_done,
                (got_wa.size() + 1 >= nf));
            chk({tag, "/kernel_at_write"}, kernel_done,
                (got_wa.size() + 1 >= nt));
            if (first_k < 0) first_k = k;
            got_wa.push_back(dma_wa);
            got_wd.push_back(dma_wd);
         end
         if (done) begin
            done_k = k;
            break;
         end
         start = (k == inj);
         tick();
      end
      start = 1'b0;
      chk({tag, "/done_cycle"}, done_k, exp_k);
      if (done_k >= 0) begin
         chk({tag, "/fmap_at_done"}, fmap_done, 1);
         chk({tag, "/kernel_at_done"}, kernel_done, 1);
         chk({tag, "/busy_at_done"}, busy, 1);
         chk({tag, "/err_start"}, err_start, (inj >= 0 && inj < done_k));
      end
      if (nt > 0) chk({tag, "/first_write"}, first_k, lat + 1);
      else        chk({tag, "/no_requests"}, nreq, 0);
      chk({tag, "/write_count"}, got_wa.size(), ewa.size());
      bad = 0;
      for (int i = 0; i < got_wa.size() && i < ewa.size(); i++)
         if (got_wa[i] !== ewa[i] || got_wd[i] !== ewd[i]) begin
            if (bad == 0)
               $display("%s first bad write %0d: wa %h/%h wd %h/%h", tag, i,
                        got_wa[i], ewa[i], got_wd[i], ewd[i]);
            bad++;
         end
      chk({tag, "/write_content"}, bad, 0);
      tick();
      chk({tag, "/idle_after"}, {done, busy}, 0);
`ifdef HWPE_DMA_PERF_CNT_EN
      chk({tag, "/perf_cycles"}, perf_cycles, done_k + 1);
`endif
      src_rsp_valid = 1'b1;
      tick();
      chk({tag, "/rsp_ignored_idle"}, dma_wen, 0);
   endtask

   initial begin
      seed = {$urandom, $urandom};
      for (int s = 0; s < 3; s++) set_seg(s, '0, '0, '0);
      #2 rst_n = 1'b0;
      #1;
      chk("reset_ctl", {src_req_valid, dma_wen, busy, done,
                        fmap_done, kernel_done, err_start}, 0);
      chk("reset_wa", dma_wa, 0);
      chk("reset_wd", dma_wd, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Full-size preload: 160 + 160 + 1760 beats.
      set_seg(0, 32'h0, 16'h0000, 16'd160);
      set_seg(1, 32'h0, 16'h4000, 16'd160);
      set_seg(2, 32'h0001_0000, 16'h8000, 16'd1760);
      run_load("full", -1, 2 * 2080);

      // Only FMAP bank 1, three beats.
      set_seg(0, 32'h100, 16'h0040, 16'd3);
      set_seg(1, 32'h0, 16'h0, 16'd0);
      set_seg(2, 32'h0, 16'h0, 16'd0);
      run_load("f1_only", -1, 6);

      // Ready held low 5 cycles on beat 2.
      set_seg(0, 32'h1000, 16'h0200, 16'd6);
      stall_addr = 32'h1010;
      stall_left = 5;
      run_load("stall", -1, 2 * 6 + 5);

      // Stray start in the middle of a load.
      set_seg(0, 32'h2000, 16'h0000, 16'd8);
      set_seg(1, 32'h3000, 16'h4000, 16'd8);
      set_seg(2, 32'h4000, 16'h8000, 16'd8);
      run_load("busy_start", 10, 48);

      // Asynchronous reset while the KERNEL segment is loading.
      set_seg(0, 32'h5000, 16'h0100, 16'd4);
      set_seg(1, 32'h6000, 16'h4100, 16'd4);
      set_seg(2, 32'h7000, 16'h8100, 16'd20);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 26; k++) tick();
      chk("pre_reset_fmap", fmap_done, 1);
      rst_n = 1'b0;
      #1;
      chk("midreset_ctl", {src_req_valid, dma_wen, busy, done,
                           fmap_done, kernel_done, err_start}, 0);
      chk("midreset_wa", dma_wa, 0);
      chk("midreset_wd", dma_wd, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      run_load("restart", -1, 2 * 28);

      // All segments empty.
      for (int s = 0; s < 3; s++) set_seg(s, 32'h0, 16'h0, 16'd0);
      run_load("all_zero", -1, 0);

      // Random segments, latencies and addresses (first one wraps).
      for (int it = 0; it < 6; it++) begin
         seed = {$urandom, $urandom};
         lat  = $urandom_range(1, 3);
         for (int s = 0; s < 3; s++)
            set_seg(s, $urandom & 32'hFFFF_FFF8, AW'($urandom) & 16'hFFF8,
                    LW'($urandom_range(0, 5)));
         if (it == 0) set_seg(2, 32'hFFFF_FFF0, 16'hFFF0, 16'd4);
         run_load($sformatf("rand%0d", it), -1,
                  (int'(c_len[0]) + int'(c_len[1]) + int'(c_len[2]))
                  * (1 + lat));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
